sr_exec_monitor: RTL

SR_EXEC_MONITOR -- requirements
Module: sr_exec_monitor

---
 rtl/sr_mon_pkg.sv | 26 ++
 rtl/sr_mon_fifo.sv | 64 ++++++
 rtl/sr_exec_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sr_mon_pkg.sv
// Shared definitions for the execution monitor: instruction encodings,
// monitor state enum and the trace record layout.
package sr_mon_pkg;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    // Record fields are sized for the widest supported configuration;
    // the monitor uses only the low PC_W / CNT_W bits.
    localparam int MAX_PC_W  = 64;
    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPED,
        ST_TIMEOUT
    } mon_state_e;

    typedef struct packed {
        logic [MAX_PC_W-1:0]  pc;
        logic [31:0]          instr;
        logic [MAX_CNT_W-1:0] cnt;
    } trace_rec_t;

endpackage

// File: rtl/sr_mon_fifo.sv
// Trace FIFO: DEPTH entries (power of 2, >= 2), synchronous clear,
// head entry visible on data_o, zero when empty.
module sr_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state: clear wins, otherwise advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    // NOTE: storage has no reset; the pointers define validity and data_o is
    // masked while empty, so stale contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sr_exec_monitor.sv
// Execution monitor: groups consecutive cycles at one PC into trace records,
// counts EBREAKs and run cycles, stops on WFI or run-cycle timeout.
// Optional trace FIFO enabled by defining SR_MON_TRACE_EN.
module sr_exec_monitor
    import sr_mon_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int TRACE_DEPTH = 8,
    parameter int TIMEOUT     = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    output logic             stop_o,
    output logic             timeout_o,
    output logic [7:0]       err_cnt_o,
    output logic [31:0]      cycle_o,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [PC_W-1:0]  trace_pc_o,
    output logic [31:0]      trace_instr_o,
    output logic [CNT_W-1:0] trace_cycles_o,
    output logic             trace_ovf_o
);

    mon_state_e  state_q, state_d;
    trace_rec_t  rec_q, rec_d;
    logic        have_rec_q, have_rec_d;
    logic        wfi_pend_q, wfi_pend_d;
    logic [7:0]  err_q, err_d;
    logic [31:0] cycle_q, cycle_d;
    logic        stop_q, stop_d;
    logic        timeout_q, timeout_d;
    logic        push, capture;

    // Upper record bits beyond PC_W/CNT_W are always zero.
    logic rec_unused;
    assign rec_unused = ^rec_q;

    // Next-state, record tracking and counter updates.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        rec_d      = rec_q;
        have_rec_d = have_rec_q;
        wfi_pend_d = 1'b0;
        err_d      = err_q;
        cycle_d    = cycle_q;
        stop_d     = stop_q;
        timeout_d  = timeout_q;
        push       = 1'b0;
        capture    = 1'b0;
        if (clear_i) begin
            state_d    = ST_IDLE;
            rec_d      = '0;
            have_rec_d = 1'b0;
            err_d      = '0;
            cycle_d    = '0;
            stop_d     = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    cycle_d = cycle_q + 32'd1;
                    if (!have_rec_q) begin
                        capture = 1'b1;
                    end else if (pc_i == rec_q.pc[PC_W-1:0]) begin
                        if (rec_q.cnt[CNT_W-1:0] != {CNT_W{1'b1}})
                            rec_d.cnt = rec_q.cnt + 1'b1;
                    end else begin
                        push    = 1'b1;
                        capture = 1'b1;
                    end
                    if (capture) begin
                        rec_d.pc    = MAX_PC_W'(pc_i);
                        rec_d.instr = instr_i;
                        rec_d.cnt   = MAX_CNT_W'(1);
                        have_rec_d  = 1'b1;
                        if (instr_i == INSTR_EBREAK && err_q != 8'hFF)
                            err_d = err_q + 8'd1;
                    end
                    // WFI wins over a timeout reached in the same cycle.
                    if (capture && instr_i == INSTR_WFI) begin
                        state_d    = ST_STOPPED;
                        stop_d     = 1'b1;
                        wfi_pend_d = 1'b1;
                    end else if (cycle_d >= 32'(TIMEOUT)) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                ST_STOPPED: begin
                    // The WFI record itself goes out on the first stopped cycle.
                    if (wfi_pend_q) push = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            rec_q      <= '0;
            have_rec_q <= 1'b0;
            wfi_pend_q <= 1'b0;
            err_q      <= '0;
            cycle_q    <= '0;
            stop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            have_rec_q <= have_rec_d;
            wfi_pend_q <= wfi_pend_d;
            err_q      <= err_d;
            cycle_q    <= cycle_d;
            stop_q     <= stop_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stop_o    = stop_q;
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_q;
    assign cycle_o   = cycle_q;

`ifdef SR_MON_TRACE_EN
    localparam int REC_W = PC_W + 32 + CNT_W;

    logic [REC_W-1:0] fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, pop;
    logic             ovf_q, ovf_d;

    assign fifo_wdata    = {rec_q.pc[PC_W-1:0], rec_q.instr, rec_q.cnt[CNT_W-1:0]};
    assign trace_valid_o = !fifo_empty;
    assign pop           = trace_valid_o && trace_ready_i;
    assign {trace_pc_o, trace_instr_o, trace_cycles_o} = fifo_rdata;
    assign trace_ovf_o   = ovf_q;

    // Sticky overflow: a push into a full FIFO with no pop is dropped.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_i)                          ovf_d = 1'b0;
        else if (push && fifo_full && !pop)   ovf_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    sr_mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign trace_valid_o  = 1'b0;
    assign trace_pc_o     = '0;
    assign trace_instr_o  = '0;
    assign trace_cycles_o = '0;
    assign trace_ovf_o    = 1'b0;

    logic trace_unused;
    assign trace_unused = ^{push, trace_ready_i, 32'(TRACE_DEPTH)};
`endif

endmodule
